// File: rtl/fir_out_requant.sv
// rtl/fir_out_requant.sv - FIR output requantizer: round, saturate, decimate, FWFT FIFO
//
// Requantizes a signed IW-bit FIR accumulator sample to OW bits with a
// round-half-up arithmetic right shift by SHIFT followed by saturation,
// keeps every DECIM-th sample, and buffers kept samples in a DEPTH-entry
// first-word-fall-through FIFO with a valid/ready output.
// Optional feature macro: FIR_REQUANT_SATCNT_EN (saturation event counter on
// oSAT_CNT); when undefined the counter is absent and oSAT_CNT reads 0.

module fir_out_requant #(
  parameter int IW    = 39,
  parameter int OW    = 16,
  parameter int SHIFT = 15,
  parameter int DECIM = 1,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     iVALID,
  input  logic [IW-1:0]            iDATA,
  output logic                     oVALID,
  input  logic                     iREADY,
  output logic [OW-1:0]            oDATA,
  output logic                     oSAT,
  output logic                     oOVF,
  output logic [$clog2(DEPTH):0]   oCOUNT,
  output logic [15:0]              oSAT_CNT
);

  localparam int AW  = $clog2(DEPTH);
  localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;

  // Rounding constant 2^(SHIFT-1) in the widened (IW+1)-bit domain.
  localparam logic [IW:0]        C_ONE   = {{IW{1'b0}}, 1'b1};
  localparam logic signed [IW:0] C_HALF  = $signed(C_ONE << (SHIFT - 1));
  // Output range limits +2^(OW-1)-1 and -2^(OW-1), sign-extended to IW+1 bits.
  localparam logic signed [IW:0] C_MAX   = $signed({{(IW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}});
  localparam logic signed [IW:0] C_MIN   = $signed({{(IW + 2 - OW){1'b1}}, {(OW - 1){1'b0}}});
  localparam logic [OW-1:0]      C_QMAX  = {1'b0, {(OW - 1){1'b1}}};
  localparam logic [OW-1:0]      C_QMIN  = {1'b1, {(OW - 1){1'b0}}};
  localparam logic [DCW-1:0]     C_DLAST = DCW'(DECIM - 1);
  localparam logic [AW:0]        C_DEPTH = (AW + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Stage 1: widen by one bit so adding the rounding constant cannot overflow,
  // then shift arithmetically (floor), which yields round-half-toward-+inf.
  // ---------------------------------------------------------------------------
  logic signed [IW:0] w_ext;
  logic signed [IW:0] w_sum;
  logic signed [IW:0] w_round;

  assign w_ext   = $signed({iDATA[IW-1], iDATA});
  assign w_sum   = w_ext + C_HALF;
  assign w_round = w_sum >>> SHIFT;

  logic               r_s1_valid;
  logic               r_s1_keep;
  logic signed [IW:0] r_s1_val;
  logic [DCW-1:0]     r_dcnt;

  // Capture the rounded sample and its keep decision; advance the decimation phase.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s1_valid <= 1'b0;
      r_s1_keep  <= 1'b0;
      r_s1_val   <= '0;
      r_dcnt     <= '0;
    end else begin
      r_s1_valid <= iVALID;
      if (iVALID) begin
        r_s1_val  <= w_round;
        r_s1_keep <= (r_dcnt == '0);
        r_dcnt    <= (r_dcnt == C_DLAST) ? '0 : r_dcnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: saturate the stage-1 value to OW bits (combinational).
  // ---------------------------------------------------------------------------
  logic          w_sat_hi;
  logic          w_sat_lo;
  logic [OW-1:0] w_q;

  assign w_sat_hi = (r_s1_val > C_MAX);
  assign w_sat_lo = (r_s1_val < C_MIN);
  assign w_q      = w_sat_hi ? C_QMAX : (w_sat_lo ? C_QMIN : r_s1_val[OW-1:0]);

  // ---------------------------------------------------------------------------
  // FIFO control. A push into a full FIFO still succeeds when the head is
  // popped in the same cycle; otherwise the sample is dropped and flagged.
  // ---------------------------------------------------------------------------
  logic          w_push;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;

  logic [OW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [OW-1:0] r_last;
  logic          r_sat;
  logic          r_ovf;

  assign w_push  = r_s1_valid & r_s1_keep;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_DEPTH);
  assign w_pop   = ~w_empty & iREADY;
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  // Sample storage; emptiness is tracked by r_count, so no reset is needed here.
  always_ff @(posedge CLK) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_q;
    end
  end

  // Pointers, occupancy and the last-popped value shown while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturation pulse for every kept sample, and the sticky drop flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sat <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_sat <= w_push & (w_sat_hi | w_sat_lo);
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign oVALID = ~w_empty;
  assign oDATA  = w_empty ? r_last : r_mem[r_rd_ptr];
  assign oSAT   = r_sat;
  assign oOVF   = r_ovf;
  assign oCOUNT = r_count;

`ifdef FIR_REQUANT_SATCNT_EN
  logic [15:0] r_sat_cnt;

  // Count saturation pulses, holding at all-ones instead of wrapping.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sat_cnt <= '0;
    end else if (r_sat && (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign oSAT_CNT = r_sat_cnt;
`else
  assign oSAT_CNT = 16'd0;
`endif

endmodule
